rr_priority_arbiter: RTL
========================

Name: rr_priority_arbiter

Overview:
- Sequential controller that shares one downstream resource among 8 requesters.
- Uses the codebase's 8-to-3 priority-encoding convention: bit 7 is the highest priority and the index is 3 bits.
- Adds two selectable policies: fixed priority, and round-robin with grant hold and a hold-timeout.
- Sits in front of the shared resource and drives a registered one-hot grant, the encoded owner index, and a valid flag.

Parameters:
- N, 8, number of requesters (RTL only needs to support 8).
- IDX_W, 3, width of grant index.
- MAX_HOLD, 16, max consecutive owned cycles before forced release; 0 disables the timeout.
- CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  8  request vector, level-sensitive, bit i = requester i.
- mode  in  1  0 = fixed priority (7 highest), 1 = round-robin.
- done  in  1  current owner finished; single-cycle pulse.
- gnt  out  8  one-hot grant, registered.
- gnt_idx  out  3  encoded owner index, registered.
- gnt_valid  out  1  high while any grant is active.
- preempt  out  1  1-cycle pulse when the owner is released by timeout.

Behaviour:
- Reset: one clk edge with rst_n=0 gives state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0. Reset mid-ownership drops gnt at that same edge; there is no GAP cycle.
- States: IDLE, OWN, GAP (encoded in the package).
- IDLE:
  - If req!=0 at edge k, go to OWN.
  - At edge k, register gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Request-to-grant latency is 1 cycle.
  - If req=0, stay in IDLE.
- Winner selection, combinational, evaluated only in IDLE/GAP:
  - mode=0: highest set index of req.
  - mode=1: descending search starting at (ptr-1) mod 8 with wrap; first set bit wins.
  - ptr is updated to the winner on every grant in both modes.
  - With ptr=0 after reset, the first round-robin search starts at 7 and matches fixed priority.
- OWN, evaluated every edge. Release when any of the following holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - On release: go to GAP with gnt=0, gnt_valid=0; gnt_idx holds its last value.
  - preempt=1 for that one cycle only if (c) caused the release and neither (a) nor (b) was true.
  - Otherwise hold_cnt increments, saturating at its max when MAX_HOLD=0.
- GAP (exactly 1 cycle, guaranteed dead turnaround):
  - If req!=0, go to OWN with a new winner, same as IDLE; otherwise go to IDLE.
  - Release-to-next-grant latency is 2 edges.
  - A timed-out owner still requesting is eligible again. Under round-robin it wins only if no other requester is set.
- Ignored inputs:
  - done while not in OWN.
  - Changes to non-owner req bits during OWN.
  - mode sampled only at arbitration edges; a mode change mid-ownership takes effect at the next arbitration.
- Invariants: gnt is one-hot or zero; gnt_valid==|gnt; gnt==(1<<gnt_idx) whenever gnt_valid=1.
- Simultaneous done and timeout: the release counts as normal and preempt=0.

Decomposition:
- Shared package/header arb_pkg:
  - state encodings ST_IDLE=2'd0, ST_OWN=2'd1, ST_GAP=2'd2;
  - MODE_FIXED=1'b0, MODE_RR=1'b1;
  - N, IDX_W constants.
- One sub-module, rr_pick: combinational block with inputs req[7:0], start[2:0], mode, and outputs idx[2:0], any.
  - Implementation: rotate req by start, 8-to-3 priority encode (bit 7 highest), un-rotate the index.
  - mode=0 forces start=7.
- The top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with req=8'hFF. Required: gnt=0, gnt_valid=0, preempt=0. Release reset with mode=0, req=8'h24 → one cycle later gnt=8'h20, gnt_idx=5, gnt_valid=1.
- Fixed priority + done:
  - mode=0, req=8'h81 held.
  - Pulse done in the 3rd OWN cycle → next cycle gnt=0 (GAP) → following cycle gnt=8'h80 again. Index 0 never wins while bit 7 is set.
- Round-robin rotation:
  - mode=1, req=8'h92 held; release each owner with done.
  - Grant order: idx 7, 4, 1, 7, 4, … with exactly one GAP cycle between grants.
- Timeout: MAX_HOLD=4, mode=1, req=8'h0C held, no done.
  - idx 3 is owned for exactly 4 cycles, then preempt=1 for 1 cycle with gnt=0.
  - Next cycle gnt_idx=2, which is owned 4 cycles; then back to idx 3.
- Owner drops request:
  - Owner idx 6 deasserts req[6] mid-ownership → gnt=0 at the next edge, preempt=0.
  - Next arbitration picks from the remaining requesters.
  - Requests arriving during OWN do not disturb gnt.
- Reset mid-operation:
  - rst_n=0 for 1 cycle while in OWN with idx 4 → gnt=0 at that edge.
  - After release, with req=8'h10 and mode=1, the grant goes to idx 4, because ptr was reset to 0 and the search starts at 7.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester arbiter: state encodings,
// arbitration modes, vector widths and a one-hot helper.
package arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: descending scan starting at 'start' with wrap.
// Fixed-priority mode pins the start to 7, which reduces to a plain 8-to-3 encoder.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] start_eff;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] rot_idx;

    assign start_eff = (mode == MODE_FIXED) ? IDX_W'(N - 1) : start;

    // Rotate so that requester 'start' lands on bit 7, 'start-1' on bit 6, ...
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            assign src     = start_eff + IDX_W'(gi + 1);
            assign rot[gi] = req[src];
        end
    endgenerate

    always_comb begin
        rot_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (rot[i]) begin
                rot_idx = IDX_W'(i);
            end
        end
    end

    assign idx = start_eff + rot_idx + IDX_W'(1);
    assign any = |req;

endmodule

// File: rtl/rr_priority_arbiter.sv
// Shares one resource among 8 requesters with fixed or round-robin policy,
// a hold timeout and a guaranteed one-cycle dead gap between owners.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             timeout;
    logic             release_own;

    // Round-robin search begins just below the previous winner.
    assign pick_start = ptr_q - IDX_W'(1);

    rr_pick u_pick (
        .req   (req),
        .start (pick_start),
        .mode  (mode),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign owner_req   = req[idx_q];
    assign timeout     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign release_own = done || !owner_req || timeout;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_any) begin
                    state_d = ST_OWN;
                    gnt_d   = idx_to_onehot(pick_idx);
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    ptr_d   = pick_idx;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            ST_OWN: begin
                if (release_own) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    // A timeout only counts as preemption when the owner still wanted the resource.
                    preempt_d = timeout && !done && owner_req;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign preempt   = preempt_q;

endmodule
